// File: rtl/cmd_exec_sched.sv
// Pulse-train execution scheduler: arms on a validated command, waits for the
// start time, then sequences blanking / transmit gates and DDS frequency words.
module cmd_exec_sched #(
    parameter int TIME_W = 64,
    parameter int FREQ_W = 48
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [TIME_W-1:0] TIME,
    input  logic              LOAD,
    input  logic              ABORT,
    input  logic [FREQ_W-1:0] FREQ,
    input  logic [FREQ_W-1:0] FREQ_STEP,
    input  logic [31:0]       FREQ_RATE,
    input  logic [TIME_W-1:0] TIME_START,
    input  logic [15:0]       N_impuls,
    input  logic [1:0]        TYPE_impulse,
    input  logic [31:0]       Interval_Ti,
    input  logic [31:0]       Interval_Tp,
    input  logic [31:0]       Tblank1,
    input  logic [31:0]       Tblank2,
    output logic              READY,
    output logic              TX_EN,
    output logic              BLANK,
    output logic [FREQ_W-1:0] DDS_FREQ,
    output logic              DDS_WR,
    output logic [15:0]       PULSE_CNT,
    output logic              CMD_DONE,
    output logic              CMD_ERR,
    output logic              CMD_LATE
);

    typedef enum logic [2:0] {IDLE, ARMED, BLANK1, PULSE, BLANK2, GAP} state_t;

    state_t            state, state_n, seg_next;
    logic [TIME_W-1:0] time_q, tstart_r;
    logic [FREQ_W-1:0] freq_r, step_r, acc, base;
    logic [31:0]       rate_r, tp_r, pc, pc_n, pc_adv, rcnt;
    logic [33:0]       b1_r, ep_r, eb2_r, sum_in, pc_x;
    logic [15:0]       n_r, pcnt, pcnt_n;
    logic [1:0]        type_r;
    logic              pc_wrap, ld, start, done_n, err_n, late_n;
    logic              pulse_first, chirp_step;

    assign READY   = (state == IDLE);
    assign sum_in  = {2'b0, Tblank1} + {2'b0, Interval_Ti} + {2'b0, Tblank2};
    assign pc_wrap = (pc == tp_r - 32'd1);
    // Position the period counter will hold next cycle if the train keeps running
    assign pc_adv  = (state == ARMED || pc_wrap) ? 32'd0 : pc + 32'd1;
    assign pc_x    = {2'b0, pc_adv};

    always_comb begin
        if (pc_x < b1_r)       seg_next = BLANK1;
        else if (pc_x < ep_r)  seg_next = PULSE;
        else if (pc_x < eb2_r) seg_next = BLANK2;
        else                   seg_next = GAP;
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        pcnt_n  = pcnt;
        ld      = 1'b0;
        start   = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        late_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (LOAD && !ABORT) begin
                    ld = 1'b1;
                    if (N_impuls == 16'd0 || Interval_Ti == 32'd0 || Interval_Tp == 32'd0 ||
                        sum_in > {2'b0, Interval_Tp})
                        err_n = 1'b1;
                    else if (TIME >= TIME_START)
                        late_n = 1'b1;
                    else
                        state_n = ARMED;
                end
            end
            ARMED: begin
                if (time_q >= tstart_r) begin
                    start   = 1'b1;
                    pc_n    = pc_adv;
                    pcnt_n  = 16'd0;
                    state_n = seg_next;
                end
            end
            default: begin
                if (pc_wrap && pcnt == n_r - 16'd1) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    if (pc_wrap) pcnt_n = pcnt + 16'd1;
                    pc_n    = pc_adv;
                    state_n = seg_next;
                end
            end
        endcase
        if (ABORT && state != IDLE) begin
            state_n = IDLE;
            start   = 1'b0;
            done_n  = 1'b0;
        end
    end

    // A pulse always begins at pc == Tblank1, which also covers back-to-back pulses
    assign pulse_first = (state_n == PULSE) && (pc_x == b1_r);
    assign chirp_step  = (state == PULSE) && (state_n == PULSE) && !pulse_first &&
                         (type_r == 2'd1) && (rate_r != 32'd0) && (rcnt + 32'd1 == rate_r);
    assign base        = start ? freq_r : acc;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            time_q    <= '0;
            tstart_r  <= '0;
            freq_r    <= '0;
            step_r    <= '0;
            acc       <= '0;
            rate_r    <= '0;
            tp_r      <= '0;
            b1_r      <= '0;
            ep_r      <= '0;
            eb2_r     <= '0;
            n_r       <= '0;
            type_r    <= '0;
            pc        <= '0;
            pcnt      <= '0;
            rcnt      <= '0;
            TX_EN     <= 1'b0;
            BLANK     <= 1'b0;
            DDS_FREQ  <= '0;
            DDS_WR    <= 1'b0;
            PULSE_CNT <= '0;
            CMD_DONE  <= 1'b0;
            CMD_ERR   <= 1'b0;
            CMD_LATE  <= 1'b0;
        end else begin
            state     <= state_n;
            time_q    <= TIME;
            pc        <= pc_n;
            pcnt      <= pcnt_n;
            PULSE_CNT <= pcnt_n;
            TX_EN     <= (state_n == PULSE);
            BLANK     <= (state_n == BLANK1) || (state_n == PULSE) || (state_n == BLANK2);
            DDS_WR    <= pulse_first || chirp_step;
            CMD_DONE  <= done_n;
            CMD_ERR   <= err_n;
            CMD_LATE  <= late_n;
            if (ld) begin
                tstart_r <= TIME_START;
                freq_r   <= FREQ;
                step_r   <= FREQ_STEP;
                rate_r   <= FREQ_RATE;
                n_r      <= N_impuls;
                type_r   <= TYPE_impulse;
                tp_r     <= Interval_Tp;
                b1_r     <= {2'b0, Tblank1};
                ep_r     <= {2'b0, Tblank1} + {2'b0, Interval_Ti};
                eb2_r    <= sum_in;
            end
            if (start) acc <= freq_r;
            if (pulse_first) begin
                rcnt <= 32'd0;
                if (type_r == 2'd2) begin
                    DDS_FREQ <= base;
                    acc      <= base + step_r;
                end else begin
                    DDS_FREQ <= freq_r;
                end
            end else if (chirp_step) begin
                DDS_FREQ <= DDS_FREQ + step_r;
                rcnt     <= 32'd0;
            end else if (state == PULSE) begin
                rcnt <= rcnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/cmd_exec_sched.md
# cmd_exec_sched

Pulse-train execution scheduler that sits after the timed command store. It accepts one command at a time (start time, frequency plan, pulse count, pulse/period intervals, blanking) and waits for the system time counter to reach the start time. It then sequences the transmitter gate, blanking gate and synthesizer frequency words for N pulses, and reports completion, rejection or lateness back to the command store.

## Interface
- TIME_W, 64, width of system time and TIME_START (ticks of CLK, 48 per µs)
- FREQ_W, 48, width of frequency words

- CLK  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- TIME  in  TIME_W  current system time, monotonically incrementing
- LOAD  in  1  one-cycle command strobe; fields below sampled on this cycle
- ABORT  in  1  cancel the current command
- FREQ, FREQ_STEP  in  FREQ_W  base frequency word / step word
- FREQ_RATE  in  32  clocks between intra-pulse steps (TYPE 1)
- TIME_START  in  TIME_W  time of first period start
- N_impuls  in  16  number of pulses
- TYPE_impulse  in  2  0 fixed, 1 intra-pulse chirp, 2 pulse-to-pulse step, 3 treated as 0
- Interval_Ti, Interval_Tp  in  32  pulse width / period, in clocks
- Tblank1, Tblank2  in  32  blanking before / after pulse, in clocks
- READY  out  1  high only in IDLE (combinational)
- TX_EN  out  1  transmitter gate
- BLANK  out  1  receiver blanking gate
- DDS_FREQ  out  FREQ_W  current frequency word
- DDS_WR  out  1  one-cycle strobe on every DDS_FREQ update
- PULSE_CNT  out  16  index of current pulse (0-based)
- CMD_DONE, CMD_ERR, CMD_LATE  out  1  one-cycle status strobes

## Operation
- States: IDLE, ARMED, BLANK1, PULSE, BLANK2, GAP.
- IDLE: LOAD registers all fields. Validation uses 34-bit sums. CMD_ERR and return to IDLE if N_impuls==0, Ti==0, Tp==0, or Tblank1+Ti+Tblank2 > Tp. Otherwise CMD_LATE and return to IDLE if TIME >= TIME_START at LOAD. Otherwise go to ARMED.
- ARMED: when sampled TIME >= TIME_START, open period 0.
- Period: counter pc runs 0..Tp-1.
  - BLANK1 while pc < Tblank1.
  - PULSE while pc < Tblank1+Ti.
  - BLANK2 while pc < Tblank1+Ti+Tblank2.
  - GAP for the rest of the period.
  - Zero-length segments are skipped with no idle cycle.
- Gates: BLANK is high in BLANK1, PULSE and BLANK2. TX_EN is high in PULSE only.
- Period end: at pc==Tp-1, if PULSE_CNT==N_impuls-1, assert CMD_DONE and go to IDLE; otherwise increment PULSE_CNT and set pc=0.
- Frequency, on the first PULSE cycle of every pulse:
  - TYPE 0/3: DDS_FREQ=FREQ.
  - TYPE 1: DDS_FREQ=FREQ, then +FREQ_STEP every FREQ_RATE clocks inside PULSE. FREQ_RATE==0 means no steps.
  - TYPE 2: DDS_FREQ=FREQ+k·FREQ_STEP for pulse k, kept as an accumulator.
  - All additions are modulo 2^FREQ_W.
  - DDS_WR pulses on every load or step, including a rewrite of an unchanged value.
- ABORT in any non-IDLE state: go to IDLE next edge, drop TX_EN/BLANK, no status strobe.
- ABORT and LOAD in the same cycle: ABORT wins and LOAD is ignored.
- LOAD outside IDLE is ignored.

## Timing
- Reset (async, immediate): state IDLE, READY=1; TX_EN, BLANK, DDS_WR, CMD_DONE, CMD_ERR, CMD_LATE =0; DDS_FREQ=0; PULSE_CNT=0.
- All outputs except READY are registered.
- CMD_ERR/CMD_LATE are asserted on the cycle after LOAD.
- Start latency: if TIME==TIME_START is sampled at edge e, BLANK (or TX_EN when Tblank1==0) is high from edge e+1. That cycle is pc=0.
- Per period: exactly Tblank1 cycles of BLANK before TX_EN, Ti cycles of TX_EN, Tblank2 cycles of BLANK after. Period length is exactly Tp cycles.
- DDS_WR coincides with the first TX_EN cycle of each pulse.
- CMD_DONE is asserted on the cycle after the last period's final cycle; READY rises on that same cycle.
- Reset mid-pulse drops TX_EN immediately and asynchronously.

## Test plan
- Basic train: FREQ=0x1000, TYPE 0, N=3, Tblank1=2, Ti=4, Tblank2=2, Tp=12, TIME_START=TIME+20.
  - TX_EN high 4 cycles per period, starting 2 cycles after BLANK rises.
  - BLANK high 8 of every 12 cycles.
  - 3 DDS_WR, each with DDS_FREQ=0x1000.
  - CMD_DONE exactly 36 cycles after the first BLANK.
- Pulse-to-pulse step: TYPE 2, FREQ=0xFFFF_FFFF_FFFF, STEP=1, N=3.
  - DDS_FREQ sequence 0xFFFF_FFFF_FFFF, 0x0, 0x1 (wrap).
- Chirp: TYPE 1, Ti=8, FREQ_RATE=3, FREQ=100, STEP=10.
  - Within each pulse DDS_FREQ is 100, 110, 120 at pulse offsets 0, 3, 6.
  - DDS_FREQ resets to 100 on the next pulse.
- Rejections:
  - Tblank1+Ti+Tblank2=Tp+1 -> CMD_ERR.
  - N=0 -> CMD_ERR.
  - TIME_START=TIME-1 -> CMD_LATE.
  - All three leave TX_EN/BLANK low and READY high.
- ABORT on the 2nd TX_EN cycle of pulse 1:
  - TX_EN/BLANK low next cycle, no CMD_DONE, READY=1.
  - A following LOAD is accepted.
- Zero blanking and busy LOAD: Tblank1=Tblank2=0, Ti=Tp=5, N=2.
  - TX_EN high 10 consecutive cycles.
  - A LOAD during this has no effect.
  - rst asserted mid-pulse zeroes all outputs asynchronously.
